// File: rtl/fetch_pkg.sv
// Shared types for the prefetching fetch unit: queue entry,
// default widths and the redirect target helper.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 16;
  localparam int FETCH_INSTR_W = 16;
  localparam int FETCH_QDEPTH  = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Wide enough for any ADDR_W up to 32; the caller truncates,
  // which gives the mod 2^ADDR_W wrap for free.
  function automatic logic [31:0] redirect_target(
    input logic        rel,
    input logic [31:0] base,
    input logic [31:0] ofs
  );
    return rel ? base + ofs : ofs;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with push/pop/flush and occupancy count.
// Ports: clk, reset, push, pop, flush, din -> head, empty, count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  QDEPTH  = FETCH_QDEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(QDEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  entry_t       din,
  output entry_t       head,
  output logic         empty,
  output logic [PW:0]  count
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(QDEPTH);

  entry_t        mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch PC, one-outstanding imem requests, redirect with stale drop.
// Ports: jmp/JmpRel/RedirBase/WBBus in, IMReq/IMAddress/IMValid/IMData
// to memory, InstrValid/InstrReady/Instr/InstrPC/PCPlus1 to decode.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = FETCH_ADDR_W,
  parameter int                 INSTR_W   = FETCH_INSTR_W,
  parameter int                 QDEPTH    = FETCH_QDEPTH,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               jmp,
  input  logic               JmpRel,
  input  logic [ADDR_W-1:0]  RedirBase,
  input  logic [ADDR_W-1:0]  WBBus,
  output logic               IMReq,
  output logic [ADDR_W-1:0]  IMAddress,
  input  logic               IMValid,
  input  logic [INSTR_W-1:0] IMData,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic [ADDR_W-1:0]  PCPlus1
);

  localparam int          CW    = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] target;
  logic              outstanding;
  logic              drop;
  logic              accept;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  entry_t            q_din;
  entry_t            q_head;

  assign target = ADDR_W'(redirect_target(JmpRel, 32'(RedirBase),
                                          32'(WBBus)));

  // A queue slot is reserved at issue time, so a response always fits.
  assign IMReq     = !reset && !outstanding && !drop && !jmp
                     && (q_count < QFULL);
  assign IMAddress = pc;

  // Responses with nothing outstanding are strays (e.g. across reset).
  assign accept = IMValid && outstanding;
  assign push   = accept && !drop && !jmp;
  assign pop    = InstrValid && InstrReady && !jmp;
  assign q_din  = '{pc: req_pc, instr: IMData};

  assign InstrValid = !q_empty;
  assign Instr      = InstrValid ? q_head.instr : '0;
  assign InstrPC    = InstrValid ? q_head.pc : '0;
  assign PCPlus1    = InstrValid ? q_head.pc + 1'b1
                                 : RESET_VEC + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VEC;
      req_pc      <= RESET_VEC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (jmp) begin
        pc <= target;
      end else if (IMReq) begin
        pc     <= pc + 1'b1;
        req_pc <= pc;
      end
      if (IMReq)       outstanding <= 1'b1;
      else if (accept) outstanding <= 1'b0;
      // A response still in flight at redirect belongs to the old path.
      if (jmp)         drop <= outstanding && !IMValid;
      else if (accept) drop <= 1'b0;
    end
  end

  fetch_queue #(
    .QDEPTH  (QDEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (jmp),
    .din   (q_din),
    .head  (q_head),
    .empty (q_empty),
    .count (q_count)
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a latency-programmable
// memory model and a second instance exercising RESET_VEC wrap.
module tb_fetch_prefetch_unit;

  logic        clk = 0;
  logic        reset = 1;
  logic        jmp = 0;
  logic        JmpRel = 0;
  logic [15:0] RedirBase = 0;
  logic [15:0] WBBus = 0;
  logic        IMReq;
  logic [15:0] IMAddress;
  logic        IMValid;
  logic [15:0] IMData;
  logic        InstrValid;
  logic        InstrReady = 0;
  logic [15:0] Instr;
  logic [15:0] InstrPC;
  logic [15:0] PCPlus1;

  logic        w_req;
  logic [15:0] w_addr;
  logic        w_valid = 0;
  logic [15:0] w_data = 0;
  logic        w_ivalid;
  logic [15:0] w_instr;
  logic [15:0] w_ipc;
  logic [15:0] w_pcp1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit dut (
    .clk(clk), .reset(reset), .jmp(jmp), .JmpRel(JmpRel),
    .RedirBase(RedirBase), .WBBus(WBBus),
    .IMReq(IMReq), .IMAddress(IMAddress),
    .IMValid(IMValid), .IMData(IMData),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .InstrPC(InstrPC), .PCPlus1(PCPlus1)
  );

  fetch_prefetch_unit #(.RESET_VEC(16'hFFFE)) u_wrap (
    .clk(clk), .reset(reset), .jmp(1'b0), .JmpRel(1'b0),
    .RedirBase(16'h0), .WBBus(16'h0),
    .IMReq(w_req), .IMAddress(w_addr),
    .IMValid(w_valid), .IMData(w_data),
    .InstrValid(w_ivalid), .InstrReady(1'b1),
    .Instr(w_instr), .InstrPC(w_ipc), .PCPlus1(w_pcp1)
  );

  // Memory model for the main instance.
  int          lat = 1;
  logic        m_kill = 1;
  logic        mv = 0;
  logic [15:0] md = 0;
  logic [15:0] m_addr = 0;
  int          m_left = 0;
  int          req_cnt = 0;
  logic        inj_v = 0;
  logic [15:0] inj_d = 0;

  assign IMValid = mv | inj_v;
  assign IMData  = inj_v ? inj_d : md;

  always @(posedge clk) begin : mem_model
    logic        r;
    logic [15:0] a;
    r = IMReq;
    a = IMAddress;
    #1;
    mv = 0;
    if (m_kill) m_left = 0;
    if (r) begin
      m_addr = a;
      m_left = lat;
      req_cnt++;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        mv = 1;
        md = m_addr + 16'h0100;
      end
    end
  end

  // One-cycle memory and request log for the wrap instance.
  logic [15:0] w_log[$];
  always @(posedge clk) begin : wrap_mem
    logic        r;
    logic [15:0] a;
    r = w_req;
    a = w_addr;
    if (reset) w_log.delete();
    else if (r) w_log.push_back(a);
    #1;
    w_valid = r;
    w_data  = a + 16'h0100;
  end

  // Entries taken by decode, as {pc, instr}.
  logic [31:0] acc_q[$];
  always @(posedge clk) begin
    if (!reset && InstrValid && InstrReady && !jmp)
      acc_q.push_back({InstrPC, Instr});
  end

  int acc_base = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench at +2 ns into the first cycle after release.
  task automatic apply_reset(input int l, input logic rdy);
    reset = 1;
    m_kill = 1;
    jmp = 0;
    inj_v = 0;
    lat = l;
    InstrReady = rdy;
    tick();
    tick();
    acc_base = acc_q.size();
    reset = 0;
    m_kill = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    m_kill = 1;
    lat = 1;
    InstrReady = 1;
    tick();
    tick();
    checks++;
    if (IMReq !== 1'b0) begin
      failures++;
      $display("FAIL rst_imreq: got %b want 0", IMReq);
    end
    checks++;
    if (InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL rst_ivalid: got %b want 0", InstrValid);
    end
    checks++;
    if (Instr !== 16'h0) begin
      failures++;
      $display("FAIL rst_instr: got %h want 0000", Instr);
    end
    checks++;
    if (InstrPC !== 16'h0) begin
      failures++;
      $display("FAIL rst_ipc: got %h want 0000", InstrPC);
    end
    checks++;
    if (PCPlus1 !== 16'h0001) begin
      failures++;
      $display("FAIL rst_pcp1: got %h want 0001", PCPlus1);
    end
    checks++;
    if (w_pcp1 !== 16'hFFFF) begin
      failures++;
      $display("FAIL rst_wrap_pcp1: got %h want ffff", w_pcp1);
    end
    acc_base = acc_q.size();
    reset = 0;
    m_kill = 0;
    #1;
    checks++;
    if (IMReq !== 1'b1 || IMAddress !== 16'h0) begin
      failures++;
      $display("FAIL lat_c1_req: got %b/%h want 1/0000",
               IMReq, IMAddress);
    end
    tick();
    checks++;
    if (IMValid !== 1'b1 || InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL lat_c2: got imvalid=%b ivalid=%b want 1/0",
               IMValid, InstrValid);
    end
    tick();
    checks++;
    if (InstrValid !== 1'b1) begin
      failures++;
      $display("FAIL lat_c3_valid: got %b want 1", InstrValid);
    end
    checks++;
    if (InstrPC !== 16'h0 || Instr !== 16'h0100) begin
      failures++;
      $display("FAIL lat_c3_head: got %h/%h want 0000/0100",
               InstrPC, Instr);
    end
    checks++;
    if (PCPlus1 !== 16'h0001) begin
      failures++;
      $display("FAIL lat_c3_pcp1: got %h want 0001", PCPlus1);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 60 && acc_q.size() < acc_base + 4; i++)
      tick();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] got;
      logic [31:0] exp;
      got = (acc_q.size() > acc_base + i) ? acc_q[acc_base+i] : 'x;
      exp = {16'(i), 16'h0100 + 16'(i)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL stream_%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int base_req;
    apply_reset(1, 1'b0);
    base_req = req_cnt;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (req_cnt - base_req !== 4) begin
      failures++;
      $display("FAIL bp_reqs: got %0d want 4", req_cnt - base_req);
    end
    checks++;
    if (IMReq !== 1'b0) begin
      failures++;
      $display("FAIL bp_imreq: got %b want 0", IMReq);
    end
    checks++;
    if (InstrValid !== 1'b1 || InstrPC !== 16'h0) begin
      failures++;
      $display("FAIL bp_head: got %b/%h want 1/0000",
               InstrValid, InstrPC);
    end
    InstrReady = 1;
    for (int i = 0; i < 60 && acc_q.size() < acc_base + 5; i++)
      tick();
    for (int i = 0; i < 5; i++) begin
      logic [31:0] got;
      logic [31:0] exp;
      got = (acc_q.size() > acc_base + i) ? acc_q[acc_base+i] : 'x;
      exp = {16'(i), 16'h0100 + 16'(i)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bp_drain_%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_jmp_abs();
    logic [31:0] got;
    apply_reset(3, 1'b1);
    tick();
    jmp = 1;
    JmpRel = 0;
    WBBus = 16'h000D;
    tick();
    jmp = 0;
    checks++;
    if (IMReq !== 1'b0 || InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL abs_drop: got req=%b ivalid=%b want 0/0",
               IMReq, InstrValid);
    end
    for (int i = 0; i < 20 && IMReq !== 1'b1; i++) tick();
    checks++;
    if (IMReq !== 1'b1 || IMAddress !== 16'h000D) begin
      failures++;
      $display("FAIL abs_target: got %b/%h want 1/000d",
               IMReq, IMAddress);
    end
    for (int i = 0; i < 40 && acc_q.size() <= acc_base; i++) tick();
    got = (acc_q.size() > acc_base) ? acc_q[acc_base] : 'x;
    checks++;
    if (got !== 32'h000D_010D) begin
      failures++;
      $display("FAIL abs_first: got %h want 000d010d", got);
    end
  endtask

  task automatic test_jmp_rel();
    apply_reset(1, 1'b1);
    jmp = 1;
    JmpRel = 1;
    RedirBase = 16'h0010;
    WBBus = 16'hFFFE;
    #1;
    checks++;
    if (IMReq !== 1'b0) begin
      failures++;
      $display("FAIL rel_noissue: got %b want 0", IMReq);
    end
    tick();
    jmp = 0;
    JmpRel = 0;
    #1;
    checks++;
    if (IMReq !== 1'b1 || IMAddress !== 16'h000E) begin
      failures++;
      $display("FAIL rel_target: got %b/%h want 1/000e",
               IMReq, IMAddress);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (w_log.size() < 3 || w_log[0] !== 16'hFFFE) begin
      failures++;
      $display("FAIL wrap_0: got n=%0d want fffe", w_log.size());
    end
    checks++;
    if (w_log.size() < 3 || w_log[1] !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_1: got n=%0d want ffff", w_log.size());
    end
    checks++;
    if (w_log.size() < 3 || w_log[2] !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_2: got n=%0d want 0000", w_log.size());
    end
  endtask

  task automatic test_jmp_collide();
    logic [31:0] got;
    apply_reset(1, 1'b0);
    for (int i = 0; i < 20 && !(IMValid && InstrValid); i++) tick();
    checks++;
    if (IMValid !== 1'b1 || InstrValid !== 1'b1) begin
      failures++;
      $display("FAIL col_setup: got %b/%b want 1/1",
               IMValid, InstrValid);
    end
    jmp = 1;
    JmpRel = 0;
    WBBus = 16'h0040;
    InstrReady = 1;
    tick();
    jmp = 0;
    #1;
    checks++;
    if (InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL col_flush: got %b want 0", InstrValid);
    end
    checks++;
    if (IMReq !== 1'b1 || IMAddress !== 16'h0040) begin
      failures++;
      $display("FAIL col_req: got %b/%h want 1/0040",
               IMReq, IMAddress);
    end
    for (int i = 0; i < 40 && acc_q.size() <= acc_base; i++) tick();
    got = (acc_q.size() > acc_base) ? acc_q[acc_base] : 'x;
    checks++;
    if (got !== 32'h0040_0140) begin
      failures++;
      $display("FAIL col_first: got %h want 00400140", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    apply_reset(4, 1'b1);
    tick();
    reset = 1;
    m_kill = 1;
    #1;
    checks++;
    if (IMReq !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_req: got %b want 0", IMReq);
    end
    tick();
    tick();
    acc_base = acc_q.size();
    lat = 1;
    reset = 0;
    m_kill = 0;
    inj_v = 1;
    inj_d = 16'hBEEF;
    #1;
    checks++;
    if (IMReq !== 1'b1 || IMAddress !== 16'h0) begin
      failures++;
      $display("FAIL mid_req: got %b/%h want 1/0000",
               IMReq, IMAddress);
    end
    tick();
    inj_v = 0;
    for (int i = 0; i < 40 && acc_q.size() <= acc_base; i++) tick();
    got = (acc_q.size() > acc_base) ? acc_q[acc_base] : 'x;
    checks++;
    if (got !== 32'h0000_0100) begin
      failures++;
      $display("FAIL mid_first: got %h want 00000100", got);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jmp_abs();
    test_jmp_rel();
    test_jmp_collide();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
